cache_mem_arbiter: RTL and testbench
====================================

# cache_mem_arbiter

Shares the single memory-side read/write port of the AXI bridge between the instruction cache and the data cache. Two read requesters (ICache, DCache) and one write requester (DCache victim/uncached store) use the cache-side `rd_req/rd_rdy/ret_*` and `wr_req/wr_rdy` protocol. The block arbitrates reads round-robin, keeps exactly one read outstanding, and routes the returned burst to its owner. A one-entry write buffer holds DCache writes and blocks any read that hits its line until the write drains.

## Interface
- `LINE_OFF`, 4: byte-offset bits per cache line; line address is `addr[31:LINE_OFF]`.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `ic_rd_req` in 1, `ic_rd_type` in 3, `ic_rd_addr` in 32: ICache read request. Type `3'b100` is a line, `3'b010` is a word.
- `ic_rd_rdy` out 1: ICache request accepted this cycle.
- `ic_ret_valid` out 1, `ic_ret_last` out 1, `ic_ret_data` out 32: ICache return beat.
- `dc_rd_req` in 1, `dc_rd_type` in 3, `dc_rd_addr` in 32, `dc_rd_rdy` out 1, `dc_ret_valid` out 1, `dc_ret_last` out 1, `dc_ret_data` out 32: DCache read port, same semantics as the ICache port.
- `dc_wr_req` in 1, `dc_wr_type` in 3, `dc_wr_addr` in 32, `dc_wr_wstrb` in 4, `dc_wr_data` in 128: DCache write request.
- `dc_wr_rdy` out 1: DCache write accepted this cycle.
- `mem_rd_req` out 1, `mem_rd_type` out 3, `mem_rd_addr` out 32, `mem_rd_rdy` in 1: bridge read request.
- `mem_ret_valid` in 1, `mem_ret_last` in 1, `mem_ret_data` in 32: bridge return beat.
- `mem_wr_req` out 1, `mem_wr_type` out 3, `mem_wr_addr` out 32, `mem_wr_wstrb` out 4, `mem_wr_data` out 128, `mem_wr_rdy` in 1: bridge write port.

## Operation
**Read FSM, two states:**
- `R_IDLE`
  - Eligible requesters are those with `*_rd_req`=1 that are not hazard-blocked.
  - The winner is the only eligible requester. If both are eligible, the winner is the one not granted last (`last_grant` register).
  - `mem_rd_req`/`type`/`addr` = winner's request, combinationally.
  - The winner's `*_rd_rdy` = `mem_rd_rdy`. The other `*_rd_rdy` = 0.
  - On `mem_rd_req && mem_rd_rdy`: latch `owner`, update `last_grant`, go to `R_WAIT`.
- `R_WAIT`
  - `mem_rd_req` = 0 and both `*_rd_rdy` = 0.
  - `mem_ret_valid`/`last`/`data` are routed to the owner's `*_ret_*`. The non-owner's `ret_valid` = 0.
  - On `mem_ret_valid && mem_ret_last`: go to `R_IDLE`.
- `ret_data` is passed through unmodified to both ports; only `ret_valid`/`ret_last` are gated.

**Write buffer, one entry:**
- `dc_wr_rdy` = !`wbuf_valid`.
- On `dc_wr_req && dc_wr_rdy`: capture type, addr, wstrb and data; `wbuf_valid` <= 1.
- `mem_wr_req` = `wbuf_valid`; `mem_wr_*` are driven from the buffer registers.
- On `mem_wr_req && mem_wr_rdy`: `wbuf_valid` <= 0.
- No fill is allowed in the drain cycle; the next accept is one cycle later at the earliest.

**Hazard rule:**
- A read is blocked while `wbuf_valid` && `rd_addr[31:LINE_OFF]` == `wbuf_addr[31:LINE_OFF]`.
- A blocked requester is excluded from arbitration, so the other requester may win that cycle.

## Timing
- **Reset values:**
  - state = `R_IDLE`, `wbuf_valid` = 0, `last_grant` = ICache (DCache wins the first tie).
  - Outputs: `ic_rd_rdy`, `dc_rd_rdy`, all `*_ret_valid`, `*_ret_last`, `mem_rd_req` and `mem_wr_req` = 0; `dc_wr_rdy` = 1.
- **Read latency:** request to `mem_rd_req` is 0 cycles (combinational) in `R_IDLE`. Return beats are routed with zero added latency.
- **Back-to-back reads:** the earliest next acceptance is the cycle after the `ret_last` beat. One read is outstanding at most.
- **Holding rule:** requesters must hold `req`/`addr` until `rdy`. A request dropped before acceptance is not remembered.
- **Write/read overlap:** the write channel is independent of the read FSM. A drain may overlap any read state.
- **Hazard clearing:** if `mem_wr_rdy` clears the buffer in cycle N, a blocked read becomes eligible in cycle N+1.
- **Reset mid-burst:** the FSM returns to `R_IDLE`, the buffer is discarded and remaining return beats are ignored. The bridge is reset together with this block.
- **Stray beats:** `mem_ret_valid` in `R_IDLE` is ignored and routed nowhere.

## Test plan
- **Single ICache line read:** `ic_rd_req`, type `100`, addr `0x1C000040`; `mem_rd_rdy`=1 in cycle 1. Expect `ic_rd_rdy`=1 in cycle 1, then four beats `0xA0..0xA3` on `ic_ret_*` with `ic_ret_last` on the 4th, and `dc_ret_valid` staying 0.
- **Simultaneous requests after reset:** both `rd_req` held high. Expect DCache to win first, ICache second after DCache's `ret_last`, and alternation after that.
- **Write then hazard read:** DCache write to `0x00001008` with `mem_wr_rdy`=0. Expect `dc_wr_rdy`=0 afterward. A DCache read of `0x00001000` gets no `mem_rd_req`, while an ICache read of `0x00002000` is granted. Raise `mem_wr_rdy`; the DCache read is issued the next cycle.
- **Write buffer full:** a second `dc_wr_req` while the buffer is full gets `dc_wr_rdy`=0 until the cycle after the drain handshake, then the new wstrb/data appear on `mem_wr_*`.
- **Uncached word read:** type `010`, `mem_ret_last` on the first beat. Expect the FSM back in `R_IDLE` the next cycle and a new request accepted.
- **Reset mid-burst:** assert `reset` after beat 2 of 4. Expect all outputs at reset values the next cycle, and later `mem_ret_valid` not forwarded.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// Shares the AXI bridge's single memory-side port between ICache and DCache:
// round-robin reads with one read outstanding, plus a one-entry DCache write buffer.
module cache_mem_arbiter #(
  parameter int LINE_OFF = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,

  input  logic         ic_rd_req_i,
  input  logic [2:0]   ic_rd_type_i,
  input  logic [31:0]  ic_rd_addr_i,
  output logic         ic_rd_rdy_o,
  output logic         ic_ret_valid_o,
  output logic         ic_ret_last_o,
  output logic [31:0]  ic_ret_data_o,

  input  logic         dc_rd_req_i,
  input  logic [2:0]   dc_rd_type_i,
  input  logic [31:0]  dc_rd_addr_i,
  output logic         dc_rd_rdy_o,
  output logic         dc_ret_valid_o,
  output logic         dc_ret_last_o,
  output logic [31:0]  dc_ret_data_o,

  input  logic         dc_wr_req_i,
  input  logic [2:0]   dc_wr_type_i,
  input  logic [31:0]  dc_wr_addr_i,
  input  logic [3:0]   dc_wr_wstrb_i,
  input  logic [127:0] dc_wr_data_i,
  output logic         dc_wr_rdy_o,

  output logic         mem_rd_req_o,
  output logic [2:0]   mem_rd_type_o,
  output logic [31:0]  mem_rd_addr_o,
  input  logic         mem_rd_rdy_i,

  input  logic         mem_ret_valid_i,
  input  logic         mem_ret_last_i,
  input  logic [31:0]  mem_ret_data_i,

  output logic         mem_wr_req_o,
  output logic [2:0]   mem_wr_type_o,
  output logic [31:0]  mem_wr_addr_o,
  output logic [3:0]   mem_wr_wstrb_o,
  output logic [127:0] mem_wr_data_o,
  input  logic         mem_wr_rdy_i
);

  typedef enum logic {
    R_IDLE = 1'b0,
    R_WAIT = 1'b1
  } rd_state_e;

  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DC = 1'b1;

  rd_state_e      state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_grant_q, last_grant_d;

  logic           wbuf_valid_q, wbuf_valid_d;
  logic [2:0]     wbuf_type_q, wbuf_type_d;
  logic [31:0]    wbuf_addr_q, wbuf_addr_d;
  logic [3:0]     wbuf_wstrb_q, wbuf_wstrb_d;
  logic [127:0]   wbuf_data_q, wbuf_data_d;

  logic           ic_blocked, dc_blocked;
  logic           ic_elig, dc_elig;
  logic           pick_dc;

  // A read to the line still sitting in the write buffer must not overtake that write.
  assign ic_blocked = wbuf_valid_q && (ic_rd_addr_i[31:LINE_OFF] == wbuf_addr_q[31:LINE_OFF]);
  assign dc_blocked = wbuf_valid_q && (dc_rd_addr_i[31:LINE_OFF] == wbuf_addr_q[31:LINE_OFF]);
  assign ic_elig    = ic_rd_req_i && !ic_blocked;
  assign dc_elig    = dc_rd_req_i && !dc_blocked;
  assign pick_dc    = dc_elig && (!ic_elig || (last_grant_q == OWN_IC));

  always_comb begin
    mem_rd_req_o   = 1'b0;
    mem_rd_type_o  = pick_dc ? dc_rd_type_i : ic_rd_type_i;
    mem_rd_addr_o  = pick_dc ? dc_rd_addr_i : ic_rd_addr_i;
    ic_rd_rdy_o    = 1'b0;
    dc_rd_rdy_o    = 1'b0;
    ic_ret_valid_o = 1'b0;
    ic_ret_last_o  = 1'b0;
    dc_ret_valid_o = 1'b0;
    dc_ret_last_o  = 1'b0;
    if (state_q == R_IDLE) begin
      mem_rd_req_o = ic_elig || dc_elig;
      ic_rd_rdy_o  = ic_elig && !pick_dc && mem_rd_rdy_i;
      dc_rd_rdy_o  = pick_dc && mem_rd_rdy_i;
    end else begin
      ic_ret_valid_o = (owner_q == OWN_IC) && mem_ret_valid_i;
      ic_ret_last_o  = (owner_q == OWN_IC) && mem_ret_last_i;
      dc_ret_valid_o = (owner_q == OWN_DC) && mem_ret_valid_i;
      dc_ret_last_o  = (owner_q == OWN_DC) && mem_ret_last_i;
    end
  end

  assign ic_ret_data_o  = mem_ret_data_i;
  assign dc_ret_data_o  = mem_ret_data_i;

  assign dc_wr_rdy_o    = !wbuf_valid_q;
  assign mem_wr_req_o   = wbuf_valid_q;
  assign mem_wr_type_o  = wbuf_type_q;
  assign mem_wr_addr_o  = wbuf_addr_q;
  assign mem_wr_wstrb_o = wbuf_wstrb_q;
  assign mem_wr_data_o  = wbuf_data_q;

  // Fill and drain are mutually exclusive because fill needs an empty buffer.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wbuf_valid_d = wbuf_valid_q;
    wbuf_type_d  = wbuf_type_q;
    wbuf_addr_d  = wbuf_addr_q;
    wbuf_wstrb_d = wbuf_wstrb_q;
    wbuf_data_d  = wbuf_data_q;
    if (state_q == R_IDLE) begin
      if (mem_rd_req_o && mem_rd_rdy_i) begin
        state_d      = R_WAIT;
        owner_d      = pick_dc;
        last_grant_d = pick_dc;
      end
    end else if (mem_ret_valid_i && mem_ret_last_i) begin
      state_d = R_IDLE;
    end
    if (!wbuf_valid_q) begin
      if (dc_wr_req_i) begin
        wbuf_valid_d = 1'b1;
        wbuf_type_d  = dc_wr_type_i;
        wbuf_addr_d  = dc_wr_addr_i;
        wbuf_wstrb_d = dc_wr_wstrb_i;
        wbuf_data_d  = dc_wr_data_i;
      end
    end else if (mem_wr_rdy_i) begin
      wbuf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= R_IDLE;
      owner_q      <= OWN_IC;
      last_grant_q <= OWN_IC;
      wbuf_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wbuf_valid_q <= wbuf_valid_d;
      wbuf_type_q  <= wbuf_type_d;
      wbuf_addr_q  <= wbuf_addr_d;
      wbuf_wstrb_q <= wbuf_wstrb_d;
      wbuf_data_q  <= wbuf_data_d;
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed vector table, reset-mid-burst sequence,
// then random traffic checked every cycle against a transaction-level model.
module tb_cache_mem_arbiter;
  localparam int LINE_OFF = 4;
  localparam logic [2:0] LN = 3'b100;
  localparam logic [2:0] WD = 3'b010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         icRdReq, dcRdReq, dcWrReq, memRdRdy, memRetValid, memRetLast, memWrRdy;
  logic [2:0]   icRdType, dcRdType, dcWrType;
  logic [31:0]  icRdAddr, dcRdAddr, dcWrAddr, memRetData;
  logic [3:0]   dcWrWstrb;
  logic [127:0] dcWrData;

  logic         icRdRdy, icRetValid, icRetLast, dcRdRdy, dcRetValid, dcRetLast, dcWrRdy;
  logic         memRdReq, memWrReq;
  logic [31:0]  icRetData, dcRetData, memRdAddr, memWrAddr;
  logic [2:0]   memRdType, memWrType;
  logic [3:0]   memWrWstrb;
  logic [127:0] memWrData;

  cache_mem_arbiter #(.LINE_OFF(LINE_OFF)) dut (
    .clk_i(clk), .reset_i(reset),
    .ic_rd_req_i(icRdReq), .ic_rd_type_i(icRdType), .ic_rd_addr_i(icRdAddr), .ic_rd_rdy_o(icRdRdy),
    .ic_ret_valid_o(icRetValid), .ic_ret_last_o(icRetLast), .ic_ret_data_o(icRetData),
    .dc_rd_req_i(dcRdReq), .dc_rd_type_i(dcRdType), .dc_rd_addr_i(dcRdAddr), .dc_rd_rdy_o(dcRdRdy),
    .dc_ret_valid_o(dcRetValid), .dc_ret_last_o(dcRetLast), .dc_ret_data_o(dcRetData),
    .dc_wr_req_i(dcWrReq), .dc_wr_type_i(dcWrType), .dc_wr_addr_i(dcWrAddr),
    .dc_wr_wstrb_i(dcWrWstrb), .dc_wr_data_i(dcWrData), .dc_wr_rdy_o(dcWrRdy),
    .mem_rd_req_o(memRdReq), .mem_rd_type_o(memRdType), .mem_rd_addr_o(memRdAddr), .mem_rd_rdy_i(memRdRdy),
    .mem_ret_valid_i(memRetValid), .mem_ret_last_i(memRetLast), .mem_ret_data_i(memRetData),
    .mem_wr_req_o(memWrReq), .mem_wr_type_o(memWrType), .mem_wr_addr_o(memWrAddr),
    .mem_wr_wstrb_o(memWrWstrb), .mem_wr_data_o(memWrData), .mem_wr_rdy_i(memWrRdy)
  );

  // exp bits, msb first: icRdy, dcRdy, memRdReq, icRetValid, dcRetValid, dcWrRdy, memWrReq
  typedef struct {
    logic         rst;
    logic         icReq;
    logic [2:0]   icType;
    logic [31:0]  icAddr;
    logic         dcReq;
    logic [2:0]   dcType;
    logic [31:0]  dcAddr;
    logic         wrReq;
    logic [2:0]   wrType;
    logic [31:0]  wrAddr;
    logic [3:0]   wrStrb;
    logic [127:0] wrData;
    logic         memRdRdy;
    logic         retV;
    logic         retL;
    logic [31:0]  retData;
    logic         memWrRdy;
    logic         chk;
    logic [6:0]   exp;
    logic [31:0]  expAddr;
  } vec_t;

  typedef struct {
    logic [2:0]   wtype;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wEntry_t;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: who owns the outstanding read (-1 none, 0 IC, 1 DC),
  // who was granted last, and the pending write as a queue of at most one entry.
  int      mOwner = -1;
  int      mLast = 0;
  int      mWinner = -1;
  wEntry_t mBuf[$];

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic icReq, logic [2:0] icType, logic [31:0] icAddr,
                              logic dcReq, logic [2:0] dcType, logic [31:0] dcAddr,
                              logic wrReq, logic [31:0] wrAddr, logic [3:0] wrStrb,
                              logic memRdRdy, logic retV, logic retL, logic [31:0] retData,
                              logic memWrRdy, logic [6:0] exp, logic [31:0] expAddr);
    vec_t v;
    v.rst = rst; v.icReq = icReq; v.icType = icType; v.icAddr = icAddr;
    v.dcReq = dcReq; v.dcType = dcType; v.dcAddr = dcAddr;
    v.wrReq = wrReq; v.wrType = LN; v.wrAddr = wrAddr; v.wrStrb = wrStrb;
    v.wrData = {wrAddr, ~wrAddr, wrAddr ^ 32'hDEADBEEF, 28'h0, wrStrb};
    v.memRdRdy = memRdRdy; v.retV = retV; v.retL = retL; v.retData = retData;
    v.memWrRdy = memWrRdy; v.chk = !rst; v.exp = exp; v.expAddr = expAddr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset = v.rst;
    icRdReq = v.icReq; icRdType = v.icType; icRdAddr = v.icAddr;
    dcRdReq = v.dcReq; dcRdType = v.dcType; dcRdAddr = v.dcAddr;
    dcWrReq = v.wrReq; dcWrType = v.wrType; dcWrAddr = v.wrAddr;
    dcWrWstrb = v.wrStrb; dcWrData = v.wrData;
    memRdRdy = v.memRdRdy; memRetValid = v.retV; memRetLast = v.retL;
    memRetData = v.retData; memWrRdy = v.memWrRdy;
  endtask

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic compareModel(input string tag);
    logic icE, dcE;
    logic [127:0] e;
    icE = icRdReq && !(mBuf.size() != 0 && (icRdAddr >> LINE_OFF) == (mBuf[0].addr >> LINE_OFF));
    dcE = dcRdReq && !(mBuf.size() != 0 && (dcRdAddr >> LINE_OFF) == (mBuf[0].addr >> LINE_OFF));
    mWinner = -1;
    if (mOwner < 0) begin
      if (icE && dcE) mWinner = 1 - mLast;
      else if (icE) mWinner = 0;
      else if (dcE) mWinner = 1;
    end
    if (reset) return;
    checkOutput({tag, ".memRdReq"}, 128'(memRdReq), 128'(mWinner >= 0));
    if (mWinner >= 0) begin
      e = 128'(mWinner == 1 ? dcRdAddr : icRdAddr);
      checkOutput({tag, ".memRdAddr"}, 128'(memRdAddr), e);
      e = 128'(mWinner == 1 ? dcRdType : icRdType);
      checkOutput({tag, ".memRdType"}, 128'(memRdType), e);
    end
    checkOutput({tag, ".icRdRdy"}, 128'(icRdRdy), 128'(mWinner == 0 && memRdRdy));
    checkOutput({tag, ".dcRdRdy"}, 128'(dcRdRdy), 128'(mWinner == 1 && memRdRdy));
    checkOutput({tag, ".icRetValid"}, 128'(icRetValid), 128'(mOwner == 0 && memRetValid));
    checkOutput({tag, ".icRetLast"}, 128'(icRetLast), 128'(mOwner == 0 && memRetLast));
    checkOutput({tag, ".dcRetValid"}, 128'(dcRetValid), 128'(mOwner == 1 && memRetValid));
    checkOutput({tag, ".dcRetLast"}, 128'(dcRetLast), 128'(mOwner == 1 && memRetLast));
    checkOutput({tag, ".icRetData"}, 128'(icRetData), 128'(memRetData));
    checkOutput({tag, ".dcRetData"}, 128'(dcRetData), 128'(memRetData));
    checkOutput({tag, ".dcWrRdy"}, 128'(dcWrRdy), 128'(mBuf.size() == 0));
    checkOutput({tag, ".memWrReq"}, 128'(memWrReq), 128'(mBuf.size() != 0));
    if (mBuf.size() != 0) begin
      checkOutput({tag, ".memWrType"}, 128'(memWrType), 128'(mBuf[0].wtype));
      checkOutput({tag, ".memWrAddr"}, 128'(memWrAddr), 128'(mBuf[0].addr));
      checkOutput({tag, ".memWrWstrb"}, 128'(memWrWstrb), 128'(mBuf[0].wstrb));
      checkOutput({tag, ".memWrData"}, memWrData, mBuf[0].data);
    end
  endtask

  task automatic updateModel();
    if (reset) begin
      mOwner = -1;
      mLast = 0;
      mBuf.delete();
    end else begin
      if (mWinner >= 0 && memRdRdy) begin
        mOwner = mWinner;
        mLast = mWinner;
      end else if (mOwner >= 0 && memRetValid && memRetLast) begin
        mOwner = -1;
      end
      if (mBuf.size() == 0) begin
        if (dcWrReq) mBuf.push_back('{dcWrType, dcWrAddr, dcWrWstrb, dcWrData});
      end else if (memWrRdy) begin
        void'(mBuf.pop_front());
      end
    end
  endtask

  task automatic checkTable(input vec_t v, input string tag);
    checkOutput({tag, ".tIcRdy"}, 128'(icRdRdy), 128'(v.exp[6]));
    checkOutput({tag, ".tDcRdy"}, 128'(dcRdRdy), 128'(v.exp[5]));
    checkOutput({tag, ".tMemRdReq"}, 128'(memRdReq), 128'(v.exp[4]));
    checkOutput({tag, ".tIcRetValid"}, 128'(icRetValid), 128'(v.exp[3]));
    checkOutput({tag, ".tDcRetValid"}, 128'(dcRetValid), 128'(v.exp[2]));
    checkOutput({tag, ".tDcWrRdy"}, 128'(dcWrRdy), 128'(v.exp[1]));
    checkOutput({tag, ".tMemWrReq"}, 128'(memWrReq), 128'(v.exp[0]));
    if (v.exp[4]) checkOutput({tag, ".tMemRdAddr"}, 128'(memRdAddr), 128'(v.expAddr));
  endtask

  task automatic runCycle(input vec_t v, input string tag);
    applyStimulus(v);
    #1;
    compareModel(tag);
    if (v.chk) checkTable(v, tag);
    updateModel();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    vec_t r;

    r = mk(1, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 0, 7'b0000000, 0);
    applyStimulus(r);
    @(negedge clk);
    runCycle(r, "rst0");
    runCycle(r, "rst1");

    // Reset values with idle inputs.
    v = mk(0, 0,0,0, 0,0,0, 0,0,0, 0, 0,0,0, 0, 7'b0000010, 0);
    applyStimulus(v);
    #1;
    checkOutput("reset.icRetLast", 128'(icRetLast), 128'(0));
    checkOutput("reset.dcRetLast", 128'(dcRetLast), 128'(0));
    runCycle(v, "reset");

    // ICache line read, then a word read issued right after ret_last, then a stray beat.
    vecs.push_back(mk(0, 1,LN,32'h1C000040, 0,WD,0, 0,0,0, 1, 0,0,0, 0, 7'b1010010, 32'h1C000040));
    vecs.push_back(mk(0, 1,WD,32'h1C000080, 0,WD,0, 0,0,0, 1, 1,0,32'hA0, 0, 7'b0001010, 0));
    vecs.push_back(mk(0, 1,WD,32'h1C000080, 0,WD,0, 0,0,0, 1, 1,0,32'hA1, 0, 7'b0001010, 0));
    vecs.push_back(mk(0, 1,WD,32'h1C000080, 0,WD,0, 0,0,0, 1, 1,0,32'hA2, 0, 7'b0001010, 0));
    vecs.push_back(mk(0, 1,WD,32'h1C000080, 0,WD,0, 0,0,0, 1, 1,1,32'hA3, 0, 7'b0001010, 0));
    vecs.push_back(mk(0, 1,WD,32'h1C000080, 0,WD,0, 0,0,0, 1, 0,0,0, 0, 7'b1010010, 32'h1C000080));
    vecs.push_back(mk(0, 0,WD,0, 0,WD,0, 0,0,0, 1, 1,1,32'h55, 0, 7'b0001010, 0));
    vecs.push_back(mk(0, 0,WD,0, 0,WD,0, 0,0,0, 1, 1,1,32'h66, 0, 7'b0000010, 0));
    vecs.push_back(r);
    // Both requesters held: DCache first after reset, then strict alternation.
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 1, 0,0,0, 0, 7'b0110010, 32'h200));
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 1, 1,1,32'h11, 0, 7'b0000110, 0));
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 1, 0,0,0, 0, 7'b1010010, 32'h100));
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 1, 1,1,32'h12, 0, 7'b0001010, 0));
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 1, 0,0,0, 0, 7'b0110010, 32'h200));
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 1, 1,1,32'h13, 0, 7'b0000110, 0));
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 0, 0,0,0, 0, 7'b0010010, 32'h100));
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 1, 0,0,0, 0, 7'b1010010, 32'h100));
    vecs.push_back(mk(0, 1,WD,32'h100, 1,WD,32'h200, 0,0,0, 1, 1,1,32'h14, 0, 7'b0001010, 0));
    vecs.push_back(r);
    // Write hazard: blocked DCache read, ICache passes, second write waits for the drain.
    vecs.push_back(mk(0, 0,WD,0, 0,WD,0, 1,32'h1008,4'hF, 0, 0,0,0, 0, 7'b0000010, 0));
    vecs.push_back(mk(0, 1,WD,32'h2000, 1,WD,32'h1000, 0,0,0, 1, 0,0,0, 0, 7'b1010001, 32'h2000));
    vecs.push_back(mk(0, 0,WD,0, 1,WD,32'h1000, 0,0,0, 1, 1,1,32'h22, 0, 7'b0001001, 0));
    vecs.push_back(mk(0, 0,WD,0, 1,WD,32'h1000, 1,32'h3000,4'h3, 1, 0,0,0, 0, 7'b0000001, 0));
    vecs.push_back(mk(0, 0,WD,0, 1,WD,32'h1000, 1,32'h3000,4'h3, 1, 0,0,0, 1, 7'b0000001, 0));
    vecs.push_back(mk(0, 0,WD,0, 1,WD,32'h1000, 1,32'h3000,4'h3, 1, 0,0,0, 0, 7'b0110010, 32'h1000));
    vecs.push_back(mk(0, 0,WD,0, 0,WD,0, 0,0,0, 0, 1,1,32'h33, 0, 7'b0000101, 0));
    vecs.push_back(mk(0, 0,WD,0, 0,WD,0, 0,0,0, 0, 0,0,0, 1, 7'b0000001, 0));
    vecs.push_back(mk(0, 0,WD,0, 0,WD,0, 0,0,0, 0, 0,0,0, 0, 7'b0000010, 0));

    for (int i = 0; i < vecs.size(); i++) runCycle(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a line burst with a write pending.
    runCycle(mk(0, 1,LN,32'h40, 0,WD,0, 1,32'h5000,4'hF, 1, 0,0,0, 0, 7'b1010010, 32'h40), "mid0");
    runCycle(mk(0, 0,WD,0, 0,WD,0, 0,0,0, 0, 1,0,32'hB0, 0, 7'b0001001, 0), "mid1");
    runCycle(mk(0, 0,WD,0, 0,WD,0, 0,0,0, 0, 1,0,32'hB1, 0, 7'b0001001, 0), "mid2");
    runCycle(mk(1, 0,WD,0, 0,WD,0, 0,0,0, 0, 1,0,32'hB2, 0, 7'b0000000, 0), "mid3");
    v = mk(0, 0,WD,0, 0,WD,0, 0,0,0, 0, 1,1,32'hB3, 0, 7'b0000010, 0);
    applyStimulus(v);
    #1;
    checkOutput("mid4.icRetLast", 128'(icRetLast), 128'(0));
    checkOutput("mid4.dcRetLast", 128'(dcRetLast), 128'(0));
    runCycle(v, "mid4");
    runCycle(mk(0, 0,WD,0, 0,WD,0, 0,0,0, 0, 1,0,32'hB4, 0, 7'b0000010, 0), "mid5");

    // Random traffic on a handful of lines so hazards and ties are frequent.
    for (int i = 0; i < 3000; i++) begin
      v.rst      = ($urandom_range(0, 99) == 0);
      v.icReq    = ($urandom_range(0, 9) < 6);
      v.icType   = $urandom_range(0, 1) ? LN : WD;
      v.icAddr   = 32'h1000 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2);
      v.dcReq    = ($urandom_range(0, 9) < 6);
      v.dcType   = $urandom_range(0, 1) ? LN : WD;
      v.dcAddr   = 32'h1000 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2);
      v.wrReq    = ($urandom_range(0, 9) < 4);
      v.wrType   = $urandom_range(0, 1) ? LN : WD;
      v.wrAddr   = 32'h1000 + ($urandom_range(0, 3) << 4) + ($urandom_range(0, 3) << 2);
      v.wrStrb   = 4'($urandom_range(0, 15));
      v.wrData   = {$urandom, $urandom, $urandom, $urandom};
      v.memRdRdy = ($urandom_range(0, 9) < 6);
      v.retV     = ($urandom_range(0, 1) == 1);
      v.retL     = ($urandom_range(0, 9) < 3);
      v.retData  = $urandom;
      v.memWrRdy = ($urandom_range(0, 9) < 3);
      v.chk      = 1'b0;
      v.exp      = 7'b0;
      v.expAddr  = 32'h0;
      runCycle(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
